// File: rtl/spi_mstr16.sv
// 16-bit SPI master, SCLK = clk/32, idle-high clock, MSB-first shift in/out.
// Optional `SPI_MSTR16_BUSY_EN adds the busy output.
module spi_mstr16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        MOSI,
    output logic        SCLK,
    output logic        SS_n,
    output logic        done,
`ifdef SPI_MSTR16_BUSY_EN
    output logic        busy,
`endif
    output logic [15:0] rd_data
);

    typedef enum logic [1:0] {IDLE, XFER, BACKPORCH} state_t;

    state_t      state_q;
    logic [15:0] shft_q;
    logic [4:0]  div_q;
    logic [4:0]  div_d;
    logic [3:0]  bitcnt_q;
    logic        miso_q;
    logic        smpl_q;
    logic        sclk_q;
    logic        ss_n_q;
    logic        done_q;

    always_comb begin
        div_d = div_q + 5'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shft_q   <= '0;
            div_q    <= '0;
            bitcnt_q <= '0;
            miso_q   <= 1'b0;
            smpl_q   <= 1'b0;
            sclk_q   <= 1'b1;
            ss_n_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wrt) begin
                        shft_q   <= cmd;
                        div_q    <= 5'b10111;
                        bitcnt_q <= '0;
                        smpl_q   <= 1'b0;
                        done_q   <= 1'b0;
                        ss_n_q   <= 1'b0;
                        state_q  <= XFER;
                    end
                end
                XFER: begin
                    div_q  <= div_d;
                    sclk_q <= div_d[4];
                    if (div_q == 5'b01111) begin
                        miso_q <= MISO;
                        smpl_q <= 1'b1;
                        if (bitcnt_q == 4'd15) begin
                            state_q <= BACKPORCH;
                        end
                    end
                    // smpl_q gates off the opening fall, which precedes any sample
                    if (div_q == 5'b11111 && smpl_q) begin
                        shft_q   <= {shft_q[14:0], miso_q};
                        bitcnt_q <= bitcnt_q + 4'd1;
                    end
                end
                BACKPORCH: begin
                    div_q <= div_d;
                    if (div_q == 5'b11111) begin
                        shft_q   <= {shft_q[14:0], miso_q};
                        bitcnt_q <= bitcnt_q + 4'd1;
                        sclk_q   <= 1'b1;
                        ss_n_q   <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        sclk_q <= div_d[4];
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SPI_MSTR16_BUSY_EN
    logic busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= (state_q != IDLE) && !(state_q == BACKPORCH && div_q == 5'b11111);
        end
    end

    assign busy = busy_q;
`endif

    assign MOSI    = shft_q[15];
    assign SCLK    = sclk_q;
    assign SS_n    = ss_n_q;
    assign done    = done_q;
    assign rd_data = shft_q;

endmodule

// File: tb/tb_spi_mstr16.sv
// Scoreboard bench for spi_mstr16: driver pushes expected word/timing, monitor
// checks on every done rise. Slave modes: loopback, constant one, shift-out slave.
module tb_spi_mstr16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrt = 1'b0;
    logic [15:0] cmd = '0;
    logic        MISO;
    logic        MOSI;
    logic        SCLK;
    logic        SS_n;
    logic        done;
    logic [15:0] rd_data;
`ifdef SPI_MSTR16_BUSY_EN
    logic        busy;
`endif

    spi_mstr16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .cmd     (cmd),
        .MISO    (MISO),
        .MOSI    (MOSI),
        .SCLK    (SCLK),
        .SS_n    (SS_n),
        .done    (done),
`ifdef SPI_MSTR16_BUSY_EN
        .busy    (busy),
`endif
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    localparam int unsigned NPAIRS = 40;

    // Slave side: mode 0 loopback, 1 constant one, 2 mode-3 shift-out slave
    int          mode = 0;
    logic        slv_bit = 1'b0;
    logic [15:0] slv_word = '0;
    logic [15:0] slv_sr = '0;

    assign MISO = (mode == 0) ? MOSI : (mode == 1) ? 1'b1 : slv_bit;

    always @(negedge SS_n) slv_sr = slv_word;

    always @(negedge SCLK) begin
        if (SS_n === 1'b0) begin
            slv_bit = slv_sr[15];
            slv_sr  = {slv_sr[14:0], 1'b0};
        end
    end

    typedef struct {
        logic [15:0] data;
        logic [31:0] due;
        bit          mosi_low;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: observes outputs one step after each rising edge
    initial begin
        logic        ss_prev = 1'b1;
        logic        sclk_prev = 1'b1;
        logic        done_prev = 1'b0;
        int          falls = 0;
        int          ss_cnt = 0;
        int          bcnt = 0;
        bit          mosi_hi = 0;
        logic [31:0] first_fall = '0;
        exp_t        e;
        forever begin
            @(posedge clk);
            #1;
            if (ss_prev === 1'b1 && SS_n === 1'b0) begin
                falls = 0; ss_cnt = 0; bcnt = 0; mosi_hi = 0; first_fall = '0;
            end
            if (SS_n === 1'b0) begin
                ss_cnt++;
                if (MOSI === 1'b1) mosi_hi = 1;
            end
            if (sclk_prev === 1'b1 && SCLK === 1'b0 && SS_n === 1'b0) begin
                falls++;
                if (falls == 1) first_fall = 32'($time - 1);
            end
`ifdef SPI_MSTR16_BUSY_EN
            if (busy === 1'b1) bcnt++;
`endif
            if (done === 1'b1 && done_prev !== 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(e.data));
                    chk("done_time", 32'($time - 1), e.due);
                    chk("sclk_falls", falls, 16);
                    chk("ss_low_clks", ss_cnt, 521);
                    chk("first_fall_time", first_fall, e.due - 32'd5210 + 32'd90);
                    if (e.mosi_low) chk("mosi_low", 32'(mosi_hi), 32'd0);
`ifdef SPI_MSTR16_BUSY_EN
                    chk("busy_clks", bcnt, 520);
`endif
                end
            end
            ss_prev   = SS_n;
            sclk_prev = SCLK;
            done_prev = done;
        end
    end

    task automatic issue(input logic [15:0] c, input logic [15:0] exp_d,
                         input bit push, input bit mlow);
        logic [31:0] t;
        @(negedge clk);
        wrt = 1'b1;
        cmd = c;
        @(posedge clk);
        t = 32'($time);
        if (push) sbq.push_back('{exp_d, t + 32'd5210, mlow});
        @(negedge clk);
        wrt = 1'b0;
        cmd = 16'($urandom);
        chk("accept_done_low", 32'(done), 32'd0);
        chk("accept_ss_low", 32'(SS_n), 32'd0);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int k = 0; k < 600 && !ok; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ok = 1;
        end
        chk("wait_done_bound", 32'(ok), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c;
        repeat (3) @(negedge clk);
        chk("rst_ss_n", 32'(SS_n), 32'd1);
        chk("rst_sclk", 32'(SCLK), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mosi", 32'(MOSI), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
`ifdef SPI_MSTR16_BUSY_EN
        chk("rst_busy", 32'(busy), 32'd0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Loopback: the received word is the transmitted word
        mode = 0;
        issue(16'hA5C3, 16'hA5C3, 1, 0);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            c = 16'($urandom);
            issue(c, c, 1, 0);
            wait_done();
        end

        // MISO stuck high: all ones back, MOSI low while selected
        mode = 1;
        issue(16'h0000, 16'hFFFF, 1, 1);
        wait_done();
        issue(16'($urandom), 16'hFFFF, 1, 0);
        wait_done();

        // Stray wrt mid-transfer must be ignored
        mode = 0;
        c = 16'($urandom);
        issue(c, c, 1, 0);
        repeat (94) @(negedge clk);
        wrt = 1'b1;
        cmd = ~c;
        @(negedge clk);
        wrt = 1'b0;
        wait_done();

        // Reset at 300 clk into a transfer aborts it
        issue(16'($urandom), 16'h0000, 0, 0);
        repeat (299) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ss_n", 32'(SS_n), 32'd1);
        chk("abort_sclk", 32'(SCLK), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
`ifdef SPI_MSTR16_BUSY_EN
        chk("abort_busy", 32'(busy), 32'd0);
`endif
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 32'(done), 32'd0);
        issue(16'h1234, 16'h1234, 1, 0);
        wait_done();

        // ADC-style slave, back-to-back pairs with a ramping second reply
        mode = 2;
        for (int i = 0; i < NPAIRS; i++) begin
            slv_word = 16'($urandom);
            issue(16'h0000, slv_word, 1, 0);
            wait_done();
            slv_word = 16'h0C00 - 16'(i) * 16'h0010;
            issue(16'h0000, slv_word, 1, 0);
            wait_done();
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
